demux2_deser: RTL and testbench

//  Downstream stage of the 1:2 bit demux: collects lane-0 and lane-1 serial bits
//  (demux select s, data d, qualified by a bit strobe) into two WIDTH-bit words.

---
 rtl/demux2_deser_pkg.sv | 17 +
 rtl/demux2_deser_lane.sv | 116 +++++++++++
 rtl/demux2_deser.sv | 70 +++++++
 tb/tb_demux2_deser.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux2_deser_pkg.sv
// Shared definitions for the 1:2 demux deserializer: default word width,
// bit-counter width helper and the per-lane state encoding.
package demux2_deser_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } lane_state_e;

  // One extra bit above the index width so WIDTH itself would be representable.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/demux2_deser_lane.sv
// One deserializer lane: LSB-first shift register, bit counter, FILL/FULL state,
// valid/ready output slot and sticky overflow. Parity output when DESER_PARITY_EN is defined.
module deser_lane
  import demux2_deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_vld_i,
  input  logic             d_i,
  input  logic             rdy_i,
  input  logic             ovf_clr_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o,
  output logic             ovf_o
`ifdef DESER_PARITY_EN
  ,
  output logic             par_o
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  lane_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ovf_q, ovf_d;
  logic             ovf_set;
  logic             slot_free;
  logic [WIDTH-1:0] word;

  // New bits enter at the top, so after WIDTH shifts the first bit sits in bit 0.
  assign word      = {d_i, shift_q[WIDTH-1:1]};
  assign slot_free = !vld_q || rdy_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    vld_d   = vld_q;
    data_d  = data_q;
    ovf_set = 1'b0;

    if (vld_q && rdy_i) vld_d = 1'b0;

    case (state_q)
      FILL: begin
        if (bit_vld_i) begin
          shift_d = word;
          if (cnt_q == LAST) begin
            cnt_d = '0;
            if (slot_free) begin
              data_d = word;
              vld_d  = 1'b1;
            end else begin
              state_d = FULL;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FULL: begin
        // The held word lives in shift_q; any bit arriving now is lost,
        // including one in the very cycle the slot frees.
        ovf_set = bit_vld_i;
        if (slot_free) begin
          data_d  = shift_q;
          vld_d   = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    ovf_d = ovf_set | (ovf_q & ~ovf_clr_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
      shift_q <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef DESER_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= ^data_d;
  end

  assign par_o = par_q;
`endif

  assign vld_o  = vld_q;
  assign data_o = data_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/demux2_deser.sv
// 1:2 bit demux deserializer top: steers strobed bits to two deser_lane instances.
// Optional per-lane parity outputs o_par0/o_par1 when DESER_PARITY_EN is defined.
module demux2_deser
  import demux2_deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_bit_vld,
  input  logic             i_sel,
  input  logic             i_d,
  output logic             o_vld0,
  input  logic             i_rdy0,
  output logic [WIDTH-1:0] o_data0,
  output logic             o_vld1,
  input  logic             i_rdy1,
  output logic [WIDTH-1:0] o_data1,
  output logic [1:0]       o_ovf,
  input  logic             i_ovf_clr
`ifdef DESER_PARITY_EN
  ,
  output logic             o_par0,
  output logic             o_par1
`endif
);

  logic bit_vld0;
  logic bit_vld1;
  logic ovf0;
  logic ovf1;

  assign bit_vld0 = i_bit_vld & ~i_sel;
  assign bit_vld1 = i_bit_vld &  i_sel;

  deser_lane #(.WIDTH(WIDTH)) u_lane0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_vld_i (bit_vld0),
    .d_i       (i_d),
    .rdy_i     (i_rdy0),
    .ovf_clr_i (i_ovf_clr),
    .vld_o     (o_vld0),
    .data_o    (o_data0),
    .ovf_o     (ovf0)
`ifdef DESER_PARITY_EN
    ,
    .par_o     (o_par0)
`endif
  );

  deser_lane #(.WIDTH(WIDTH)) u_lane1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_vld_i (bit_vld1),
    .d_i       (i_d),
    .rdy_i     (i_rdy1),
    .ovf_clr_i (i_ovf_clr),
    .vld_o     (o_vld1),
    .data_o    (o_data1),
    .ovf_o     (ovf1)
`ifdef DESER_PARITY_EN
    ,
    .par_o     (o_par1)
`endif
  );

  assign o_ovf = {ovf1, ovf0};

endmodule

// File: tb/tb_demux2_deser.sv
// Self-checking bench for demux2_deser (WIDTH=4): vector table, directed corner
// sequences and random traffic against a word-level reference model.
module tb_demux2_deser;

  logic       clk;
  logic       rst_n;
  logic       i_bit_vld, i_sel, i_d;
  logic       i_rdy0, i_rdy1, i_ovf_clr;
  logic       o_vld0, o_vld1;
  logic [3:0] o_data0, o_data1;
  logic [1:0] o_ovf;
`ifdef DESER_PARITY_EN
  logic       o_par0, o_par1;
`endif

  int checks = 0;
  int errors = 0;

  demux2_deser #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_bit_vld (i_bit_vld),
    .i_sel     (i_sel),
    .i_d       (i_d),
    .o_vld0    (o_vld0),
    .i_rdy0    (i_rdy0),
    .o_data0   (o_data0),
    .o_vld1    (o_vld1),
    .i_rdy1    (i_rdy1),
    .o_data1   (o_data1),
    .o_ovf     (o_ovf),
    .i_ovf_clr (i_ovf_clr)
`ifdef DESER_PARITY_EN
    ,
    .o_par0    (o_par0),
    .o_par1    (o_par1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bits collected by position, at most one finished word waiting.
  int         m_n   [2];
  logic [3:0] m_acc [2];
  bit         m_pend[2];
  logic [3:0] m_pw  [2];
  bit         m_v   [2];
  logic [3:0] m_dat [2];
  bit         m_ovf [2];

  task automatic m_reset();
    for (int l = 0; l < 2; l++) begin
      m_n[l] = 0; m_acc[l] = 4'd0; m_pend[l] = 0; m_pw[l] = 4'd0;
      m_v[l] = 0; m_dat[l] = 4'd0; m_ovf[l] = 0;
    end
  endtask

  task automatic m_clock();
    for (int l = 0; l < 2; l++) begin
      bit bv, rdy, free, drop;
      bv   = i_bit_vld && (i_sel == (l == 1));
      rdy  = (l == 1) ? i_rdy1 : i_rdy0;
      free = !m_v[l] || rdy;
      drop = 0;
      if (m_v[l] && rdy) m_v[l] = 0;
      if (m_pend[l]) begin
        if (bv) drop = 1;
        if (free) begin
          m_dat[l] = m_pw[l]; m_v[l] = 1; m_pend[l] = 0;
        end
      end else if (bv) begin
        m_acc[l][m_n[l]] = i_d;
        m_n[l]++;
        if (m_n[l] == 4) begin
          m_n[l] = 0;
          if (free) begin
            m_dat[l] = m_acc[l]; m_v[l] = 1;
          end else begin
            m_pw[l] = m_acc[l]; m_pend[l] = 1;
          end
        end
      end
      if (drop) m_ovf[l] = 1;
      else if (i_ovf_clr) m_ovf[l] = 0;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("m_vld0",  int'(o_vld0),  int'(m_v[0]));
    chk("m_data0", int'(o_data0), int'(m_dat[0]));
    chk("m_vld1",  int'(o_vld1),  int'(m_v[1]));
    chk("m_data1", int'(o_data1), int'(m_dat[1]));
    chk("m_ovf",   int'(o_ovf),   int'({m_ovf[1], m_ovf[0]}));
`ifdef DESER_PARITY_EN
    chk("m_par0",  int'(o_par0),  int'(^m_dat[0]));
    chk("m_par1",  int'(o_par1),  int'(^m_dat[1]));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    m_clock();
    #1;
    chk_model();
  endtask

  task automatic drive(input logic bv, input logic sel, input logic d);
    i_bit_vld = bv; i_sel = sel; i_d = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vld0"},  int'(o_vld0),  0);
    chk({tag, "_data0"}, int'(o_data0), 0);
    chk({tag, "_vld1"},  int'(o_vld1),  0);
    chk({tag, "_data1"}, int'(o_data1), 0);
    chk({tag, "_ovf"},   int'(o_ovf),   0);
`ifdef DESER_PARITY_EN
    chk({tag, "_par0"},  int'(o_par0),  0);
    chk({tag, "_par1"},  int'(o_par1),  0);
`endif
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero(tag);
    m_reset();
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic       bv, sel, d, r0, r1;
    logic       ev0;
    logic [3:0] ed0;
    logic       ev1;
    logic [3:0] ed1;
    logic [1:0] eovf;
  } vec_t;

  function automatic vec_t mk(logic bv, logic sel, logic d, logic ev0, logic [3:0] ed0,
                              logic ev1, logic [3:0] ed1);
    vec_t v;
    v.bv = bv; v.sel = sel; v.d = d; v.r0 = 1'b1; v.r1 = 1'b1;
    v.ev0 = ev0; v.ed0 = ed0; v.ev1 = ev1; v.ed1 = ed1; v.eovf = 2'b00;
    return v;
  endfunction

  vec_t tbl[14];

  initial begin
    int pulses;
    logic [3:0] pat0;
    logic [3:0] pat1;

    tbl[0]  = mk(1, 0, 1, 0, 4'b0000, 0, 4'b0000);
    tbl[1]  = mk(1, 0, 0, 0, 4'b0000, 0, 4'b0000);
    tbl[2]  = mk(1, 0, 1, 0, 4'b0000, 0, 4'b0000);
    tbl[3]  = mk(1, 0, 1, 1, 4'b1101, 0, 4'b0000);
    tbl[4]  = mk(0, 0, 0, 0, 4'b1101, 0, 4'b0000);
    tbl[5]  = mk(1, 0, 0, 0, 4'b1101, 0, 4'b0000);
    tbl[6]  = mk(1, 1, 1, 0, 4'b1101, 0, 4'b0000);
    tbl[7]  = mk(1, 0, 0, 0, 4'b1101, 0, 4'b0000);
    tbl[8]  = mk(1, 1, 1, 0, 4'b1101, 0, 4'b0000);
    tbl[9]  = mk(1, 0, 0, 0, 4'b1101, 0, 4'b0000);
    tbl[10] = mk(1, 1, 1, 0, 4'b1101, 0, 4'b0000);
    tbl[11] = mk(1, 0, 0, 1, 4'b0000, 0, 4'b0000);
    tbl[12] = mk(1, 1, 1, 0, 4'b0000, 1, 4'b1111);
    tbl[13] = mk(0, 0, 0, 0, 4'b0000, 0, 4'b1111);

    rst_n = 1'b0;
    drive(0, 0, 0);
    i_rdy0 = 1'b1; i_rdy1 = 1'b1; i_ovf_clr = 1'b0;
    m_reset();
    #12;
    chk_all_zero("rst");
    rst_n = 1'b1;

    // Single lane-0 word, then interleaved lanes.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].bv, tbl[i].sel, tbl[i].d);
      i_rdy0 = tbl[i].r0; i_rdy1 = tbl[i].r1;
      step();
      chk($sformatf("tbl%0d_vld0", i),  int'(o_vld0),  int'(tbl[i].ev0));
      chk($sformatf("tbl%0d_data0", i), int'(o_data0), int'(tbl[i].ed0));
      chk($sformatf("tbl%0d_vld1", i),  int'(o_vld1),  int'(tbl[i].ev1));
      chk($sformatf("tbl%0d_data1", i), int'(o_data1), int'(tbl[i].ed1));
      chk($sformatf("tbl%0d_ovf", i),   int'(o_ovf),   int'(tbl[i].eovf));
    end

    // Async reset while a word is held and ovf is set.
    i_rdy0 = 1'b0;
    for (int i = 0; i < 9; i++) begin drive(1, 0, 1); step(); end
    chk("pre_rst_vld0", int'(o_vld0), 1);
    chk("pre_rst_ovf",  int'(o_ovf),  1);
    async_reset("arst");

    // Stalled lane 0: two words stored, ninth bit dropped even with clr asserted.
    pat0 = 4'b0011; pat1 = 4'b1010;
    for (int i = 0; i < 4; i++) begin drive(1, 0, pat0[i]); step(); end
    for (int i = 0; i < 4; i++) begin drive(1, 0, pat1[i]); step(); end
    chk("stall_ovf_before", int'(o_ovf), 0);
    drive(1, 0, 1); i_ovf_clr = 1'b1;
    step();
    i_ovf_clr = 1'b0;
    chk("stall_ovf_set",  int'(o_ovf),   1);
    chk("stall_vld0",     int'(o_vld0),  1);
    chk("stall_data0",    int'(o_data0), 4'b0011);
    drive(0, 0, 0); i_rdy0 = 1'b1;
    step();
    chk("b2b_vld0",  int'(o_vld0),  1);
    chk("b2b_data0", int'(o_data0), 4'b1010);
    step();
    chk("b2b_drain_vld0", int'(o_vld0), 0);
    chk("ovf_sticky",     int'(o_ovf),  1);
    i_ovf_clr = 1'b1;
    step();
    i_ovf_clr = 1'b0;
    chk("ovf_clr", int'(o_ovf), 0);

    // Continuous strobe on lane 1: one word every 4 cycles.
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 1'($urandom_range(0, 1)));
      step();
      if (o_vld1) pulses++;
    end
    drive(0, 0, 0);
    chk("stream_words", pulses, 4);
    chk("stream_ovf",   int'(o_ovf), 0);

    // Reset mid-word discards the partial word.
    step();
    drive(1, 0, 1); step(); step();
    async_reset("midword");
    pat0 = 4'b0010;
    for (int i = 0; i < 4; i++) begin drive(1, 0, pat0[i]); step(); end
    chk("midword_vld0",  int'(o_vld0),  1);
    chk("midword_data0", int'(o_data0), 4'b0010);

    // Parity patterns.
    pat0 = 4'b1101; pat1 = 4'b0110;
    for (int i = 0; i < 4; i++) begin drive(1, 0, pat0[i]); step(); end
    chk("par_w1_data0", int'(o_data0), 4'b1101);
`ifdef DESER_PARITY_EN
    chk("par_w1", int'(o_par0), 1);
`endif
    for (int i = 0; i < 4; i++) begin drive(1, 0, pat1[i]); step(); end
    chk("par_w2_data0", int'(o_data0), 4'b0110);
`ifdef DESER_PARITY_EN
    chk("par_w2", int'(o_par0), 0);
`endif

    // Random traffic with backpressure and occasional clears.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      i_rdy0    = 1'($urandom_range(0, 2) != 0);
      i_rdy1    = 1'($urandom_range(0, 3) == 0);
      i_ovf_clr = 1'($urandom_range(0, 19) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
